// File: rtl/vram_scan_arbiter_if.sv
// Bus bundles for the framebuffer arbiter: the drawing-client port and the
// single-port RAM port. The arbiter is the slave of the client bus and the master of the RAM bus.

interface vram_cl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              cl_req;
    logic              cl_we;
    logic [ADDR_W-1:0] cl_addr;
    logic [DATA_W-1:0] cl_wdata;
    logic              cl_gnt;
    logic              cl_rvalid;
    logic [DATA_W-1:0] cl_rdata;

    modport master (
        output cl_req, cl_we, cl_addr, cl_wdata,
        input  cl_gnt, cl_rvalid, cl_rdata
    );

    modport slave (
        input  cl_req, cl_we, cl_addr, cl_wdata,
        output cl_gnt, cl_rvalid, cl_rdata
    );
endinterface

interface vram_mem_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Shares the framebuffer RAM between beam-locked display fetches and one drawing
// client, unpacks fetched words into pixel indices, and swaps frame bases at vblank.

module vram_scan_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 16,
    parameter int PIX_PER_WORD = 4,
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 521,
    localparam int PIX_W       = DATA_W / PIX_PER_WORD
) (
    input  logic              clk_pix,
    input  logic              resetn,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              de,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              cfg_swap,
    output logic              swap_done,
    vram_cl_if.slave          cl,
    vram_mem_if.master        mem,
    output logic [PIX_W-1:0]  pix_idx,
    output logic              pix_de
);

    localparam logic [9:0] H_LAST_FETCH = 10'(H_VISIBLE - 2 * PIX_PER_WORD);
    localparam logic [9:0] H_WRAP_FETCH = 10'(H_TOTAL - PIX_PER_WORD);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] PHASE_MASK   = 10'(PIX_PER_WORD - 1);

    logic [ADDR_W-1:0] active_base;
    logic [ADDR_W-1:0] pending_base;
    logic              pending;
    logic [ADDR_W-1:0] fetch_cnt;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] hold_word;
    logic [DATA_W-1:0] shift_word;
    logic              disp_rd_d;

    logic [9:0] next_line;
    logic       word_phase0;
    logic       disp_slot;
    logic       frame_fetch;
    logic       apply_cycle;

    assign next_line   = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    assign word_phase0 = (hcount & PHASE_MASK) == 10'd0;
    assign frame_fetch = (hcount == H_WRAP_FETCH) && (vcount == V_LAST);
    assign apply_cycle = (hcount == 10'd0) && (vcount == V_VIS);

    // Word 0 of each line is fetched at the end of the previous line so every
    // word lands one full word-time ahead of its first pixel.
    assign disp_slot = ((vcount < V_VIS) && word_phase0 && (hcount <= H_LAST_FETCH)) ||
                       ((hcount == H_WRAP_FETCH) && (next_line < V_VIS));

    assign fetch_addr = frame_fetch ? active_base : fetch_cnt;

    assign cl.cl_gnt   = cl.cl_req & ~disp_slot & ~resetn;
    assign cl.cl_rdata = cl.cl_rvalid ? mem.mem_rdata : '0;

    always_comb begin
        mem.mem_en    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (!resetn) begin
            if (disp_slot) begin
                mem.mem_en   = 1'b1;
                mem.mem_addr = fetch_addr;
            end else if (cl.cl_req) begin
                mem.mem_en    = 1'b1;
                mem.mem_we    = cl.cl_we;
                mem.mem_addr  = cl.cl_addr;
                mem.mem_wdata = cl.cl_wdata;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (resetn) begin
            fetch_cnt    <= '0;
            disp_rd_d    <= 1'b0;
            hold_word    <= '0;
            shift_word   <= '0;
            pix_idx      <= '0;
            pix_de       <= 1'b0;
            cl.cl_rvalid <= 1'b0;
        end else begin
            if (disp_slot) begin
                fetch_cnt <= fetch_addr + ADDR_W'(1);
            end
            disp_rd_d    <= disp_slot;
            cl.cl_rvalid <= cl.cl_gnt & ~cl.cl_we;

            // Holding register frees the RAM output for the next word while the
            // shift register is still draining the current one.
            if (disp_rd_d) begin
                hold_word <= mem.mem_rdata;
            end

            pix_de <= de;
            if (de && word_phase0) begin
                pix_idx    <= hold_word[PIX_W-1:0];
                shift_word <= hold_word >> PIX_W;
            end else if (de) begin
                pix_idx    <= shift_word[PIX_W-1:0];
                shift_word <= shift_word >> PIX_W;
            end else begin
                pix_idx <= '0;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (resetn) begin
            active_base  <= '0;
            pending_base <= '0;
            pending      <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            if (apply_cycle) begin
                // A request arriving in the apply cycle itself is newer than any pending one.
                if (cfg_swap) begin
                    active_base <= cfg_base;
                    pending     <= 1'b0;
                    swap_done   <= 1'b1;
                end else if (pending) begin
                    active_base <= pending_base;
                    pending     <= 1'b0;
                    swap_done   <= 1'b1;
                end
            end else if (cfg_swap) begin
                pending      <= 1'b1;
                pending_base <= cfg_base;
            end
        end
    end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Randomized bench for vram_scan_arbiter on a reduced raster; a beam-position
// reference model predicts every RAM access, grant, pixel and swap pulse.

module tb_vram_scan_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    localparam int PPW    = 4;
    localparam int PIX_W  = DATA_W / PPW;
    localparam int HV     = 64;
    localparam int VV     = 48;
    localparam int HT     = 80;
    localparam int VT     = 53;
    localparam int WPL    = HV / PPW;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic              clk_pix = 1'b0;
    logic              resetn;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              de;
    logic [ADDR_W-1:0] cfg_base;
    logic              cfg_swap;
    logic              swap_done;
    logic [PIX_W-1:0]  pix_idx;
    logic              pix_de;

    vram_cl_if  #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cl_bus ();
    vram_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    vram_scan_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_PER_WORD(PPW),
        .H_VISIBLE(HV), .V_VISIBLE(VV), .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .clk_pix  (clk_pix),
        .resetn   (resetn),
        .hcount   (hcount),
        .vcount   (vcount),
        .de       (de),
        .cfg_base (cfg_base),
        .cfg_swap (cfg_swap),
        .swap_done(swap_done),
        .cl       (cl_bus),
        .mem      (mem_bus),
        .pix_idx  (pix_idx),
        .pix_de   (pix_de)
    );

    always #5 clk_pix = ~clk_pix;

    int n_tests = 0;
    int n_fail  = 0;
    int frame   = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (frame %0d v %0d h %0d t %0t)",
                     tag, obs, exp, frame, vcount, hcount, $time);
        end
    endtask

    // Behavioural RAM: one-cycle read latency.
    logic [DATA_W-1:0] ram [0:AMASK];
    initial begin
        for (int i = 0; i <= AMASK; i++) ram[i] = DATA_W'($urandom);
        ram[0] = 16'h3210;
        forever begin
            @(posedge clk_pix);
            if (mem_bus.mem_en) begin
                if (mem_bus.mem_we) ram[mem_bus.mem_addr] = mem_bus.mem_wdata;
                else mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
            end
        end
    end

    // Reference model state (values the DUT should hold after the next edge)
    int   m_act_base   = 0;
    int   m_pend_base  = 0;
    bit   m_pend       = 0;
    int   m_frame_base = 0;
    bit   m_valid      = 0;
    bit   exp_pix_de   = 0;
    int   exp_pix_idx  = 0;
    bit   exp_pix_chk  = 1;
    bit   exp_sd       = 0;
    bit   exp_rv       = 0;
    int   exp_rdata    = 0;
    int   fcount       = 0;
    bit   fcount_valid = 0;
    int   sd_cnt       = 0;
    bit   granted      = 0;

    always @(negedge clk_pix) begin : mdl
        int h, v, k, l, ea, wa;
        bit slot_m, gnt_m, fstart, disp_obs, apply;
        h = int'(hcount);
        v = int'(vcount);
        k = ((h + PPW) % HT) / PPW;
        l = (h >= HT - PPW) ? ((v == VT - 1) ? 0 : v + 1) : v;
        slot_m = (h % PPW == 0) && (k < WPL) && (l < VV);
        fstart = (h == HT - PPW) && (v == VT - 1);
        apply  = (h == 0) && (v == VV);
        gnt_m  = cl_bus.cl_req && !slot_m && !resetn;

        chk("pix_de", 32'(pix_de), 32'(exp_pix_de));
        if (exp_pix_chk) chk("pix_idx", 32'(pix_idx), 32'(exp_pix_idx));
        chk("swap_done", 32'(swap_done), 32'(exp_sd));
        chk("cl_rvalid", 32'(cl_bus.cl_rvalid), 32'(exp_rv));
        if (exp_rv) chk("cl_rdata", 32'(cl_bus.cl_rdata), 32'(exp_rdata));
        if (swap_done) sd_cnt++;

        if (resetn) begin
            chk("rst_mem_en", 32'(mem_bus.mem_en), 32'd0);
            chk("rst_cl_gnt", 32'(cl_bus.cl_gnt), 32'd0);
            m_act_base = 0; m_pend = 0; m_valid = 0;
            exp_pix_de = 0; exp_pix_idx = 0; exp_pix_chk = 1;
            exp_sd = 0; exp_rv = 0; fcount_valid = 0; fcount = 0;
            granted = 0;
        end else begin
            chk("cl_gnt", 32'(cl_bus.cl_gnt), 32'(gnt_m));
            chk("mem_en", 32'(mem_bus.mem_en), 32'(slot_m || gnt_m));
            if (slot_m) begin
                chk("disp_we", 32'(mem_bus.mem_we), 32'd0);
                if (fstart) chk("frame_addr", 32'(mem_bus.mem_addr), 32'(m_act_base));
                else if (m_valid) begin
                    ea = (m_frame_base + l * WPL + k) & AMASK;
                    chk("fetch_addr", 32'(mem_bus.mem_addr), 32'(ea));
                end
            end
            if (gnt_m) begin
                chk("cl_we", 32'(mem_bus.mem_we), 32'(cl_bus.cl_we));
                chk("cl_addr", 32'(mem_bus.mem_addr), 32'(cl_bus.cl_addr));
                if (cl_bus.cl_we) chk("cl_wdata", 32'(mem_bus.mem_wdata), 32'(cl_bus.cl_wdata));
            end
            granted   = gnt_m;
            exp_rv    = gnt_m && !cl_bus.cl_we;
            exp_rdata = int'(ram[cl_bus.cl_addr]);

            disp_obs = mem_bus.mem_en && !cl_bus.cl_gnt;
            if (fstart) begin
                if (fcount_valid) chk("fetch_count", 32'(fcount), 32'(VV * WPL));
                fcount = disp_obs ? 1 : 0;
                fcount_valid = 1;
                m_frame_base = m_act_base;
                m_valid = 1;
            end else if (disp_obs) fcount++;

            exp_pix_de = de;
            if (!de) begin
                exp_pix_idx = 0; exp_pix_chk = 1;
            end else if (m_valid) begin
                wa = (m_frame_base + v * WPL + h / PPW) & AMASK;
                exp_pix_idx = (int'(ram[wa]) >> (PIX_W * (h % PPW))) & ((1 << PIX_W) - 1);
                exp_pix_chk = 1;
            end else exp_pix_chk = 0;

            exp_sd = 0;
            if (apply && cfg_swap) begin
                m_act_base = int'(cfg_base); m_pend = 0; exp_sd = 1;
            end else if (apply && m_pend) begin
                m_act_base = m_pend_base; m_pend = 0; exp_sd = 1;
            end else if (!apply && cfg_swap) begin
                m_pend = 1; m_pend_base = int'(cfg_base);
            end
        end
    end

    task automatic new_client_req();
        cl_bus.cl_req   = ($urandom_range(0, 3) != 0);
        cl_bus.cl_we    = 1'($urandom_range(0, 1));
        cl_bus.cl_addr  = ADDR_W'(17'h08000 + $urandom_range(0, 63));
        cl_bus.cl_wdata = DATA_W'($urandom);
    endtask

    initial begin
        bit done;
        done     = 0;
        hcount   = 10'd0;
        vcount   = 10'(VT - 1);
        de       = 1'b0;
        resetn   = 1'b1;
        cfg_swap = 1'b0;
        cfg_base = '0;
        cl_bus.cl_req   = 1'b0;
        cl_bus.cl_we    = 1'b0;
        cl_bus.cl_addr  = '0;
        cl_bus.cl_wdata = '0;

        for (int c = 0; c < 30000 && !done; c++) begin
            @(posedge clk_pix);
            #1;
            if (c > 0) begin
                if (int'(hcount) == HT - 1) begin
                    hcount = 10'd0;
                    vcount = (int'(vcount) == VT - 1) ? 10'd0 : vcount + 10'd1;
                    if (vcount == 10'd0) frame++;
                end else hcount = hcount + 10'd1;
            end
            de = (int'(hcount) < HV) && (int'(vcount) < VV);

            resetn = (c < 3) ||
                     (frame == 2 && vcount == 10'd20 && hcount >= 10'd30 && hcount <= 10'd32);

            cfg_swap = 1'b0;
            cfg_base = ADDR_W'($urandom);
            if (frame == 0 && vcount == 10'd10 && hcount == 10'd5) begin
                cfg_swap = 1'b1; cfg_base = 17'h12C00;
            end else if (frame == 1 && vcount == 10'd3 && hcount == 10'd0) begin
                cfg_swap = 1'b1; cfg_base = 17'h05000;
            end else if (frame == 1 && vcount == 10'd7 && hcount == 10'd9) begin
                cfg_swap = 1'b1; cfg_base = 17'h06000;
            end else if (frame == 1 && int'(vcount) == VV && hcount == 10'd0) begin
                cfg_swap = 1'b1; cfg_base = 17'h07000;
            end else if (frame == 3 && vcount == 10'd2 && hcount == 10'd40) begin
                cfg_swap = 1'b1; cfg_base = 17'h1FF80;
            end

            if (granted || !cl_bus.cl_req) begin
                if (frame == 0 && vcount == 10'd5 && hcount == 10'd0) begin
                    cl_bus.cl_req = 1'b1; cl_bus.cl_we = 1'b1;
                    cl_bus.cl_addr = 17'h08100; cl_bus.cl_wdata = 16'hBEEF;
                end else if (frame == 0 && vcount == 10'd5 && hcount == 10'd6) begin
                    cl_bus.cl_req = 1'b1; cl_bus.cl_we = 1'b0;
                    cl_bus.cl_addr = 17'h08100; cl_bus.cl_wdata = '0;
                end else new_client_req();
            end

            if (frame == 5 && vcount == 10'd1) done = 1;
        end
        @(negedge clk_pix);
        chk("run_complete", 32'(done), 32'd1);
        chk("swap_pulses", 32'(sd_cnt), 32'd3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
